// File: rtl/aead_seq_ctrl.sv
// aead_seq_ctrl: sequences one ChaCha20-Poly1305 AEAD operation (config, AAD, keystream/payload, length block, tag).
module aead_seq_ctrl #(
    parameter int LEN_W     = 32,
    parameter int BLK_BYTES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_decrypt,
    input  logic [LEN_W-1:0] cmd_aad_len,
    input  logic [LEN_W-1:0] cmd_pld_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [15:0]      out_keep,
    output logic             out_last,
    output logic             tag_valid,
    input  logic             tag_ready,
    output logic [127:0]     tag,
    output logic             busy,
    output logic             core_cfg_we,
    output logic             core_ks_req,
    input  logic             core_ks_valid,
    input  logic [511:0]     core_ks_data,
    output logic             core_aad_valid,
    input  logic             core_aad_ready,
    output logic [127:0]     core_aad_data,
    output logic [15:0]      core_aad_keep,
    output logic             core_pld_valid,
    input  logic             core_pld_ready,
    output logic [127:0]     core_pld_data,
    output logic [15:0]      core_pld_keep,
    output logic             core_len_valid,
    input  logic             core_len_ready,
    output logic [127:0]     core_len_block,
    input  logic             core_tag_pre_xor_valid,
    input  logic             core_tagmask_valid,
    input  logic [127:0]     core_tag_pre_xor,
    input  logic [127:0]     core_tagmask
);
    localparam logic [LEN_W-1:0] BLK = LEN_W'(BLK_BYTES);
    typedef enum logic [3:0] {IDLE, CFG, AAD, KS_REQ, KS_WAIT, PLD, LEN, TAG_WAIT, TAG_OUT} state_t;
    state_t state_q;
    logic             dec_q, hold_q, out_done_q, pld_done_q, last_q, pre_v_q, mask_v_q;
    logic [LEN_W-1:0] aad_rem_q, pld_rem_q, tot_aad_q, tot_pld_q;
    logic [511:0]     ks_q;
    logic [1:0]       lane_q;
    logic [15:0]      keep_q;
    logic [127:0]     out_data_q, poly_q, pre_q, mask_q, tag_q;
    logic [15:0]      aad_keep, pld_keep;
    logic [127:0]     pld_in, pld_xor, pre_n, mask_n;
    logic             aad_fire, in_fire, out_fire, pld_fire, retire, pre_v, mask_v;

    function automatic logic [15:0] keep_of(input logic [LEN_W-1:0] rem);
        return (rem >= BLK) ? 16'hFFFF : (16'd1 << rem[3:0]) - 16'd1;
    endfunction

    function automatic logic [127:0] byte_mask(input logic [15:0] k);
        logic [127:0] m;
        for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    function automatic logic [LEN_W-1:0] dec_rem(input logic [LEN_W-1:0] rem);
        return (rem >= BLK) ? rem - BLK : '0;
    endfunction

    assign aad_keep       = keep_of(aad_rem_q);
    assign pld_keep       = keep_of(pld_rem_q);
    assign pld_in         = in_data & byte_mask(pld_keep);
    assign pld_xor        = (in_data ^ ks_q[{lane_q, 7'd0} +: 128]) & byte_mask(pld_keep);
    assign cmd_ready      = state_q == IDLE;
    assign busy           = state_q != IDLE;
    assign core_cfg_we    = state_q == CFG;
    assign core_ks_req    = state_q == KS_REQ;
    assign in_ready       = (state_q == AAD) ? core_aad_ready : (state_q == PLD) && !hold_q;
    assign core_aad_valid = (state_q == AAD) && in_valid;
    assign core_aad_keep  = (state_q == AAD) ? aad_keep : '0;
    assign core_aad_data  = (state_q == AAD) ? in_data & byte_mask(aad_keep) : '0;
    assign out_valid      = (state_q == PLD) && hold_q && !out_done_q;
    assign out_data       = out_data_q;
    assign out_keep       = keep_q;
    assign out_last       = last_q;
    assign core_pld_valid = (state_q == PLD) && hold_q && !pld_done_q;
    assign core_pld_data  = poly_q;
    assign core_pld_keep  = keep_q;
    assign core_len_valid = state_q == LEN;
    assign core_len_block = {64'(tot_pld_q), 64'(tot_aad_q)};
    assign tag_valid      = state_q == TAG_OUT;
    assign tag            = tag_q;
    assign aad_fire       = core_aad_valid && core_aad_ready;
    assign in_fire        = (state_q == PLD) && in_valid && !hold_q;
    assign out_fire       = out_valid && out_ready;
    assign pld_fire       = core_pld_valid && core_pld_ready;
    // a block retires once both consumers have taken it, in either order
    assign retire         = (state_q == PLD) && hold_q && (out_done_q || out_fire) && (pld_done_q || pld_fire);
    assign pre_v          = pre_v_q || core_tag_pre_xor_valid;
    assign mask_v         = mask_v_q || core_tagmask_valid;
    assign pre_n          = core_tag_pre_xor_valid ? core_tag_pre_xor : pre_q;
    assign mask_n         = core_tagmask_valid ? core_tagmask : mask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dec_q      <= 1'b0;
            hold_q     <= 1'b0;
            out_done_q <= 1'b0;
            pld_done_q <= 1'b0;
            last_q     <= 1'b0;
            pre_v_q    <= 1'b0;
            mask_v_q   <= 1'b0;
            aad_rem_q  <= '0;
            pld_rem_q  <= '0;
            tot_aad_q  <= '0;
            tot_pld_q  <= '0;
            ks_q       <= '0;
            lane_q     <= '0;
            keep_q     <= '0;
            out_data_q <= '0;
            poly_q     <= '0;
            pre_q      <= '0;
            mask_q     <= '0;
            tag_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (cmd_valid) begin
                    dec_q     <= cmd_decrypt;
                    aad_rem_q <= cmd_aad_len;
                    pld_rem_q <= cmd_pld_len;
                    tot_aad_q <= cmd_aad_len;
                    tot_pld_q <= cmd_pld_len;
                    hold_q    <= 1'b0;
                    pre_v_q   <= 1'b0;
                    mask_v_q  <= 1'b0;
                    state_q   <= CFG;
                end
                CFG: state_q <= (aad_rem_q != '0) ? AAD : (pld_rem_q != '0) ? KS_REQ : LEN;
                AAD: if (aad_fire) begin
                    aad_rem_q <= dec_rem(aad_rem_q);
                    if (aad_rem_q <= BLK) state_q <= (pld_rem_q != '0) ? KS_REQ : LEN;
                end
                KS_REQ: state_q <= KS_WAIT;
                KS_WAIT: if (core_ks_valid) begin
                    ks_q    <= core_ks_data;
                    lane_q  <= 2'd0;
                    state_q <= PLD;
                end
                PLD: begin
                    if (in_fire) begin
                        hold_q     <= 1'b1;
                        out_done_q <= 1'b0;
                        pld_done_q <= 1'b0;
                        out_data_q <= pld_xor;
                        keep_q     <= pld_keep;
                        last_q     <= pld_rem_q <= BLK;
                        poly_q     <= dec_q ? pld_in : pld_xor;
                    end
                    if (out_fire) out_done_q <= 1'b1;
                    if (pld_fire) pld_done_q <= 1'b1;
                    if (retire) begin
                        hold_q    <= 1'b0;
                        lane_q    <= lane_q + 2'd1;
                        pld_rem_q <= dec_rem(pld_rem_q);
                        state_q   <= (pld_rem_q <= BLK) ? LEN : (lane_q == 2'd3) ? KS_REQ : PLD;
                    end
                end
                LEN: if (core_len_ready) state_q <= TAG_WAIT;
                TAG_WAIT: begin
                    if (core_tag_pre_xor_valid) begin
                        pre_q   <= core_tag_pre_xor;
                        pre_v_q <= 1'b1;
                    end
                    if (core_tagmask_valid) begin
                        mask_q   <= core_tagmask;
                        mask_v_q <= 1'b1;
                    end
                    if (pre_v && mask_v) begin
                        tag_q   <= pre_n ^ mask_n;
                        state_q <= TAG_OUT;
                    end
                end
                TAG_OUT: if (tag_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aead_seq_ctrl.sv
// tb_aead_seq_ctrl: randomized bench checking aead_seq_ctrl against a block-level AEAD sequencing model.
module tb_aead_seq_ctrl;
    logic         clk = 1'b0, rst = 1'b1;
    logic         cmd_valid, cmd_ready, cmd_decrypt;
    logic [31:0]  cmd_aad_len, cmd_pld_len;
    logic         in_valid, in_ready, out_valid, out_ready, out_last;
    logic [127:0] in_data, out_data, tag;
    logic [15:0]  out_keep;
    logic         tag_valid, tag_ready, busy, core_cfg_we, core_ks_req, core_ks_valid;
    logic [511:0] core_ks_data;
    logic         core_aad_valid, core_aad_ready, core_pld_valid, core_pld_ready;
    logic [127:0] core_aad_data, core_pld_data, core_len_block, core_tag_pre_xor, core_tagmask;
    logic [15:0]  core_aad_keep, core_pld_keep;
    logic         core_len_valid, core_len_ready, core_tag_pre_xor_valid, core_tagmask_valid;
    int n_test = 0, n_fail = 0;

    always #5 clk = ~clk;

    aead_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_decrypt(cmd_decrypt),
        .cmd_aad_len(cmd_aad_len), .cmd_pld_len(cmd_pld_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last),
        .tag_valid(tag_valid), .tag_ready(tag_ready), .tag(tag), .busy(busy),
        .core_cfg_we(core_cfg_we), .core_ks_req(core_ks_req),
        .core_ks_valid(core_ks_valid), .core_ks_data(core_ks_data),
        .core_aad_valid(core_aad_valid), .core_aad_ready(core_aad_ready),
        .core_aad_data(core_aad_data), .core_aad_keep(core_aad_keep),
        .core_pld_valid(core_pld_valid), .core_pld_ready(core_pld_ready),
        .core_pld_data(core_pld_data), .core_pld_keep(core_pld_keep),
        .core_len_valid(core_len_valid), .core_len_ready(core_len_ready),
        .core_len_block(core_len_block),
        .core_tag_pre_xor_valid(core_tag_pre_xor_valid), .core_tagmask_valid(core_tagmask_valid),
        .core_tag_pre_xor(core_tag_pre_xor), .core_tagmask(core_tagmask)
    );

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_test++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [15:0] keep_ref(input int bytes);
        logic [15:0] k = '0;
        for (int i = 0; i < bytes && i < 16; i++) k[i] = 1'b1;
        return k;
    endfunction

    function automatic logic [127:0] bmask(input int bytes);
        logic [127:0] m = '0;
        for (int i = 0; i < bytes && i < 16; i++) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // payload block j uses request j/4, lane j%4 counted from the LSB of the 512-bit keystream
    function automatic logic [127:0] cipher(input logic [127:0] d, input logic [511:0] k, input int j, input int bytes);
        return (d ^ k[128*(j%4) +: 128]) & bmask(bytes);
    endfunction

    task automatic run_op(input logic dec, input int aad_len, input int pld_len, input bit bp, input bit abort);
        int n_aad = (aad_len + 15) / 16;
        int n_pld = (pld_len + 15) / 16;
        logic [127:0] host [$];
        logic [511:0] ks [$];
        logic [127:0] pre = rnd128();
        logic [127:0] msk = rnd128();
        logic [127:0] clr, ct;
        logic [511:0] kw;
        int hidx = 0, aidx = 0, oidx = 0, pidx = 0, b = 0, cyc = 0;
        int cfg_cnt = 0, ks_cnt = 0, ks_dly = -1, dly_p = -1, dly_m = -1;
        int out_stall = 0, bp_pld = 0, tag_wait = 0;
        bit done = 0, cmd_acc, in_acc;
        for (int i = 0; i < n_aad + n_pld; i++) host.push_back(rnd128());
        cmd_valid = 1'b1;
        cmd_decrypt = dec;
        cmd_aad_len = aad_len;
        cmd_pld_len = pld_len;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            cmd_acc = cmd_valid && cmd_ready;
            in_acc = in_valid && in_ready;
            if (core_cfg_we) cfg_cnt++;
            if (core_ks_req) begin
                chk("ks_req_after_retires", {32'(oidx), 32'(pidx)}, {32'(ks_cnt * 4), 32'(ks_cnt * 4)});
                ks_cnt++;
                ks.push_back({rnd128(), rnd128(), rnd128(), rnd128()});
                ks_dly = $urandom_range(0, 3);
            end
            if (core_aad_valid && core_aad_ready) begin
                b = aad_len - 16 * aidx;
                chk("aad_data", core_aad_data, host[aidx] & bmask(b));
                chk("aad_keep", core_aad_keep, keep_ref(b));
                aidx++;
            end
            if (bp && oidx == 0 && out_valid && !out_ready) begin
                chk("out_hold", out_data, cipher(host[n_aad], ks[0], 0, pld_len));
                out_stall++;
            end
            if (core_pld_valid && core_pld_ready) begin
                b = pld_len - 16 * pidx;
                kw = ks[pidx / 4];
                clr = host[n_aad + pidx] & bmask(b);
                ct = cipher(host[n_aad + pidx], kw, pidx, b);
                chk("pld_data", core_pld_data, dec ? clr : ct);
                chk("pld_keep", core_pld_keep, keep_ref(b));
                if (bp && oidx == 0) bp_pld++;
                pidx++;
            end
            if (out_valid && out_ready) begin
                b = pld_len - 16 * oidx;
                kw = ks[oidx / 4];
                chk("out_data", out_data, cipher(host[n_aad + oidx], kw, oidx, b));
                chk("out_keep", out_keep, keep_ref(b));
                chk("out_last", out_last, oidx == n_pld - 1);
                if (bp && oidx == 0) chk("bp_single_pld", bp_pld, 1);
                oidx++;
            end
            if (core_len_valid && core_len_ready) begin
                chk("len_block", core_len_block, (128'(pld_len) << 64) | 128'(aad_len));
                dly_p = bp ? 4 : $urandom_range(0, 4);
                dly_m = bp ? 0 : $urandom_range(0, 4);
            end
            if (tag_valid) begin
                chk("tag", tag, pre ^ msk);
                if (tag_ready) done = 1; else tag_wait++;
            end
            @(posedge clk);
            #1;
            if (abort && oidx >= 1) begin
                rst = 1'b1;
                {cmd_valid, in_valid, core_ks_valid, core_tag_pre_xor_valid, core_tagmask_valid} = '0;
                repeat (2) begin
                    @(negedge clk);
                    chk("rst_quiet", {core_cfg_we, core_ks_req, core_aad_valid, core_pld_valid, core_len_valid,
                                      out_valid, tag_valid, in_ready, busy}, '0);
                end
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                chk("cmd_ready_after_rst", {cmd_ready, busy}, 2'b10);
                return;
            end
            if (cmd_acc) cmd_valid = 1'b0;
            if (in_acc) hidx++;
            in_valid = (hidx < host.size()) && ($urandom_range(0, 3) != 0);
            in_data = (hidx < host.size()) ? host[hidx] : rnd128();
            out_ready = bp ? (oidx > 0 || out_stall >= 5) : ($urandom_range(0, 2) != 0);
            core_pld_ready = bp ? 1'b1 : ($urandom_range(0, 2) != 0);
            core_aad_ready = $urandom_range(0, 2) != 0;
            core_len_ready = $urandom_range(0, 1) != 0;
            tag_ready = bp ? (tag_wait >= 3) : ($urandom_range(0, 1) != 0);
            core_ks_valid = ks_dly == 0;
            core_ks_data = (ks_dly == 0) ? ks[ks.size() - 1] : {rnd128(), rnd128(), rnd128(), rnd128()};
            if (ks_dly >= 0) ks_dly--;
            core_tag_pre_xor_valid = dly_p == 0;
            core_tag_pre_xor = (dly_p == 0) ? pre : rnd128();
            if (dly_p >= 0) dly_p--;
            core_tagmask_valid = dly_m == 0;
            core_tagmask = (dly_m == 0) ? msk : rnd128();
            if (dly_m >= 0) dly_m--;
        end
        chk("op_completed", done, 1'b1);
        chk("cfg_we_count", cfg_cnt, 1);
        chk("ks_req_count", ks_cnt, (n_pld + 3) / 4);
        chk("aad_count", aidx, n_aad);
        chk("out_count", oidx, n_pld);
        chk("pld_count", pidx, n_pld);
        if (bp) chk("tag_hold_cycles", tag_wait, 3);
        @(negedge clk);
        chk("idle_after_tag", {cmd_ready, busy}, 2'b10);
    endtask

    initial begin
        {cmd_valid, cmd_decrypt, in_valid, out_ready, tag_ready, core_ks_valid} = '0;
        {core_aad_ready, core_pld_ready, core_len_ready, core_tag_pre_xor_valid, core_tagmask_valid} = '0;
        cmd_aad_len = '0;
        cmd_pld_len = '0;
        in_data = '0;
        core_ks_data = '0;
        core_tag_pre_xor = '0;
        core_tagmask = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy, in_ready, out_valid, out_keep, out_last, tag_valid, core_cfg_we, core_ks_req,
                              core_aad_valid, core_pld_valid, core_len_valid, out_data, tag, core_len_block}, '0);
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        run_op(1'b0, 32, 64, 1'b0, 1'b0);
        run_op(1'b0, 20, 0, 1'b0, 1'b0);
        run_op(1'b0, 0, 80, 1'b0, 1'b0);
        run_op(1'b1, 0, 17, 1'b0, 1'b0);
        run_op(1'b0, 16, 64, 1'b1, 1'b0);
        run_op(1'b0, 0, 0, 1'b0, 1'b0);
        run_op(1'b1, 5, 48, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            run_op(1'($urandom_range(0, 1)), $urandom_range(0, 70), $urandom_range(0, 140), 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end
endmodule
